// File: rtl/frame_sched_pkg.sv
// Shared types and sizing helpers for the per-frame access scheduler.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAP  = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Bits needed to hold a frame counter running 0..period-1.
  function automatic int cnt_width(input int period);
    return (period > 2) ? $clog2(period) : 1;
  endfunction

  // Bits needed to index one of n channels.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sched_arbiter.sv
// Combinational single-winner arbiter: fixed lowest-index priority or
// round-robin starting just after the previous winner.
module sched_arbiter
  import frame_sched_pkg::*;
#(
  parameter int NCH  = 3,
  parameter int MODE = MODE_FIXED,
  parameter int IW   = 2
) (
  input  logic [NCH-1:0] req_vec,
  input  logic [IW-1:0]  last,
  output logic           valid,
  output logic [IW-1:0]  winner
);

  logic found;
  int   idx;

  // Scan the request vector in the order dictated by MODE; first hit wins.
  always_comb begin
    valid  = |req_vec;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (MODE == MODE_RR) begin
      for (int k = 1; k <= NCH; k++) begin
        idx = (int'(last) + k) % NCH;
        if (!found && req_vec[idx]) begin
          found  = 1'b1;
          winner = IW'(idx);
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!found && req_vec[i]) begin
          found  = 1'b1;
          winner = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/frame_access_scheduler.sv
// Per-frame access sequencer: constant-length frame counter, read-refresh
// window at frame start, one arbitrated capture+write grant per frame.
module frame_access_scheduler
  import frame_sched_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int PERIOD   = 396,
  parameter int READ_LEN = 3,
  parameter int SLOT     = 288,
  parameter int WR_LEN   = 4,
  parameter int MODE     = MODE_FIXED
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NCH-1:0]            req,
  output logic                      frame_start,
  output logic                      read_en,
  output logic [NCH-1:0]            cap_en,
  output logic [NCH-1:0]            wr_en,
  output logic [id_width(NCH)-1:0]  grant_id,
  output logic                      busy
);

  localparam int CW = cnt_width(PERIOD);
  localparam int IW = id_width(NCH);

  localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_SLOT   = CW'(SLOT);
  localparam logic [CW-1:0] CNT_WR_END = CW'(SLOT + 1 + WR_LEN);
  localparam logic [CW-1:0] CNT_READ   = CW'(READ_LEN);

  logic [CW-1:0]  cnt_q, cnt_d;
  state_e         state_q, state_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [IW-1:0]  last_q, last_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic           frame_start_q, frame_start_d;
  logic           read_en_q, read_en_d;
  logic [NCH-1:0] cap_en_q, cap_en_d;
  logic [NCH-1:0] wr_en_q, wr_en_d;
  logic           busy_q, busy_d;

  logic [NCH-1:0] arb_req;
  logic           arb_valid;
  logic [IW-1:0]  arb_winner;
  logic [NCH-1:0] gnt_oh;

  // Latched requests plus live ones, so a request on the slot cycle itself still counts.
  assign arb_req = pend_q | req;

  sched_arbiter #(
    .NCH  (NCH),
    .MODE (MODE),
    .IW   (IW)
  ) u_arb (
    .req_vec (arb_req),
    .last    (last_q),
    .valid   (arb_valid),
    .winner  (arb_winner)
  );

  // Next-state logic: counter wrap, grant FSM, pending latch and output decode.
  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (cnt_q == CNT_SLOT && arb_valid) begin
          state_d = ST_CAP;
          grant_d = arb_winner;
          last_d  = arb_winner;
        end
      end
      ST_CAP:  state_d = ST_WR;
      ST_WR:   if (cnt_q == CNT_WR_END) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Clear beats set: a request arriving on the capture cycle must be re-asserted.
    pend_d = (pend_q | req) & ~cap_en_q;

    for (int i = 0; i < NCH; i++) begin
      gnt_oh[i] = (grant_d == IW'(i));
    end

    // Outputs are decoded from next state so they line up with the counter value.
    frame_start_d = (cnt_d == '0);
    read_en_d     = (cnt_d < CNT_READ);
    cap_en_d      = (state_d == ST_CAP) ? gnt_oh : '0;
    wr_en_d       = (state_d == ST_WR)  ? gnt_oh : '0;
    busy_d        = (state_d != ST_IDLE);
  end

  // All state and registered outputs; reset parks the counter one before frame start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q         <= CNT_LAST;
      state_q       <= ST_IDLE;
      pend_q        <= '0;
      last_q        <= IW'(NCH - 1);
      grant_q       <= '0;
      frame_start_q <= 1'b0;
      read_en_q     <= 1'b0;
      cap_en_q      <= '0;
      wr_en_q       <= '0;
      busy_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      pend_q        <= pend_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      frame_start_q <= frame_start_d;
      read_en_q     <= read_en_d;
      cap_en_q      <= cap_en_d;
      wr_en_q       <= wr_en_d;
      busy_q        <= busy_d;
    end
  end

  assign frame_start = frame_start_q;
  assign read_en     = read_en_q;
  assign cap_en      = cap_en_q;
  assign wr_en       = wr_en_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_frame_access_scheduler.sv
// Bench for frame_access_scheduler: one fixed-priority and one round-robin
// instance share stimulus and are compared every cycle to a frame-level model.
module tb_frame_access_scheduler;

  localparam int NCH      = 3;
  localparam int PERIOD   = 396;
  localparam int READ_LEN = 3;
  localparam int SLOT     = 288;
  localparam int WR_LEN   = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] req   = 3'b000;

  logic       fs0, re0, busy0, fs1, re1, busy1;
  logic [2:0] cap0, wr0, cap1, wr1;
  logic [1:0] gid0, gid1;

  frame_access_scheduler #(.NCH(NCH), .PERIOD(PERIOD), .READ_LEN(READ_LEN),
                           .SLOT(SLOT), .WR_LEN(WR_LEN), .MODE(0)) u0 (
    .clock(clock), .reset(reset), .req(req), .frame_start(fs0), .read_en(re0),
    .cap_en(cap0), .wr_en(wr0), .grant_id(gid0), .busy(busy0));

  frame_access_scheduler #(.NCH(NCH), .PERIOD(PERIOD), .READ_LEN(READ_LEN),
                           .SLOT(SLOT), .WR_LEN(WR_LEN), .MODE(1)) u1 (
    .clock(clock), .reset(reset), .req(req), .frame_start(fs1), .read_en(re1),
    .cap_en(cap1), .wr_en(wr1), .grant_id(gid1), .busy(busy1));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame position, pending set, last winner, this frame's grant.
  int         m_cnt;
  logic [2:0] m_pend [2];
  int         m_last [2];
  bit         m_has  [2];
  int         m_win  [2];

  typedef struct {
    logic [2:0] rq;
    int         at;
    logic [2:0] e0;
    logic [2:0] e1;
    logic [2:0] n0;
    logic [2:0] n1;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = PERIOD - 1;
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = 3'b000;
      m_last[m] = NCH - 1;
      m_has[m]  = 1'b0;
      m_win[m]  = 0;
    end
  endtask

  function automatic logic [2:0] onehot(input int i);
    logic [2:0] v;
    v    = 3'b000;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int oh_index(input logic [2:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [10:0] expected(input int m);
    logic [2:0] c, w;
    logic       b;
    c = (m_has[m] && m_cnt == SLOT + 1) ? onehot(m_win[m]) : 3'b000;
    w = (m_has[m] && m_cnt >= SLOT + 2 && m_cnt <= SLOT + 1 + WR_LEN) ? onehot(m_win[m]) : 3'b000;
    b = (c != 3'b000) || (w != 3'b000);
    return {(m_cnt == 0), (m_cnt < READ_LEN), c, w, b, b ? 2'(m_win[m]) : 2'b00};
  endfunction

  function automatic logic [10:0] got_of(input int m);
    if (m == 0) return {fs0, re0, cap0, wr0, busy0, busy0 ? gid0 : 2'b00};
    return {fs1, re1, cap1, wr1, busy1, busy1 ? gid1 : 2'b00};
  endfunction

  // Advance the model by one clock using the req value present before the edge.
  task automatic model_pre();
    logic [2:0] cap_now, cand;
    for (int m = 0; m < 2; m++) begin
      cap_now = (m_has[m] && m_cnt == SLOT + 1) ? onehot(m_win[m]) : 3'b000;
      if (m_cnt == SLOT) begin
        cand     = m_pend[m] | req;
        m_has[m] = (cand != 3'b000);
        if (m_has[m]) begin
          if (m == 0) begin
            m_win[m] = oh_index(cand);
          end else begin
            for (int k = NCH; k >= 1; k--)
              if (cand[(m_last[m] + k) % NCH]) m_win[m] = (m_last[m] + k) % NCH;
            m_last[m] = m_win[m];
          end
        end
      end
      m_pend[m] = (m_pend[m] | req) & ~cap_now;
    end
    m_cnt = (m_cnt + 1) % PERIOD;
  endtask

  task automatic step();
    model_pre();
    @(posedge clock);
    #1;
    check("fixed_prio_outputs", 32'(got_of(0)), 32'(expected(0)));
    check("round_robin_outputs", 32'(got_of(1)), 32'(expected(1)));
  endtask

  task automatic wait_cnt(input int target);
    int n;
    step();
    n = 1;
    while (m_cnt != target && n < PERIOD + 2) begin
      step();
      n++;
    end
    if (m_cnt != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cnt: reached %0d required %0d", m_cnt, target);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req   = 3'b000;
    model_reset();
    #1;
    check("reset_outputs_u0", 32'(got_of(0)), 32'd0);
    check("reset_outputs_u1", 32'(got_of(1)), 32'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int fs_cnt, re_cnt, busy_cnt, r;

    vecs[0] = '{3'b010, 100, 3'b010, 3'b010, 3'b000, 3'b000};
    vecs[1] = '{3'b100, 300, 3'b100, 3'b100, 3'b000, 3'b000};
    vecs[2] = '{3'b110,  50, 3'b010, 3'b010, 3'b100, 3'b100};
    vecs[3] = '{3'b101, 288, 3'b001, 3'b001, 3'b100, 3'b100};
    vecs[4] = '{3'b001, 289, 3'b001, 3'b001, 3'b000, 3'b000};
    vecs[5] = '{3'b011,   0, 3'b001, 3'b001, 3'b010, 3'b010};

    // Idle frames after reset
    do_reset();
    fs_cnt = 0; re_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 3 * PERIOD; c++) begin
      step();
      fs_cnt += int'(fs0);
      re_cnt += int'(re0);
      busy_cnt += int'(busy0) + int'(busy1);
      if (c % PERIOD == 0) check("frame_start_pulse", 32'(fs0), 32'd1);
    end
    check("frame_start_count", fs_cnt, 3);
    check("read_en_count", re_cnt, 3 * READ_LEN);
    check("idle_busy_count", busy_cnt, 0);

    // Table-driven single-shot requests
    foreach (vecs[v]) begin
      do_reset();
      wait_cnt(vecs[v].at);
      req = vecs[v].rq;
      step();
      req = 3'b000;
      if (m_cnt != SLOT + 1) wait_cnt(SLOT + 1);
      check("vec_cap_fixed", 32'(cap0), 32'(vecs[v].e0));
      check("vec_cap_rr", 32'(cap1), 32'(vecs[v].e1));
      check("vec_gid_fixed", 32'(gid0), 32'(oh_index(vecs[v].e0)));
      check("vec_gid_rr", 32'(gid1), 32'(oh_index(vecs[v].e1)));
      for (int j = 0; j < WR_LEN; j++) begin
        step();
        check("vec_wr_fixed", 32'(wr0), 32'(vecs[v].e0));
        check("vec_wr_rr", 32'(wr1), 32'(vecs[v].e1));
      end
      step();
      check("vec_wr_end", 32'({wr0, wr1, busy0, busy1}), 32'd0);
      wait_cnt(SLOT + 1);
      check("vec_next_fixed", 32'(cap0), 32'(vecs[v].n0));
      check("vec_next_rr", 32'(cap1), 32'(vecs[v].n1));
    end

    // All channels held for three frames
    do_reset();
    req = 3'b111;
    for (int f = 0; f < 3; f++) begin
      wait_cnt(SLOT + 1);
      check("held_fixed_grant", 32'(cap0), 32'b001);
      check("held_rr_grant", 32'(cap1), 32'(onehot(f)));
    end
    req = 3'b000;

    // Reset asserted in the middle of a write window
    do_reset();
    wait_cnt(10);
    req = 3'b001;
    step();
    req = 3'b000;
    wait_cnt(SLOT + 3);
    check("midwr_active", 32'(wr0), 32'b001);
    #2;
    reset = 1'b0;
    #1;
    check("midwr_drop_u0", 32'(got_of(0)), 32'd0);
    check("midwr_drop_u1", 32'(got_of(1)), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step();
    check("midwr_restart", 32'({fs0, re0}), 32'b11);
    busy_cnt = 0;
    for (int c = 0; c < PERIOD; c++) begin
      step();
      busy_cnt += int'(busy0) + int'(busy1);
    end
    check("midwr_no_resume", busy_cnt, 0);

    // Randomised traffic
    do_reset();
    for (int c = 0; c < 20 * PERIOD; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) req = 3'($urandom_range(1, 7));
      else if (r >= 85) req = 3'b000;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_access_scheduler.md
# frame_access_scheduler

Parametrised per-frame access sequencer for the RTC/display datapath. Every frame of `PERIOD` clocks it issues a read-refresh window. At a fixed arbitration slot it grants at most one of `NCH` requesting channels (hour, date, chrono, …). The winner gets a one-cycle capture strobe followed by a multi-cycle write window. Unlike the previous three-channel controller, it generalises channel count and timing, latches short requests, keeps frame length constant, and offers fixed-priority or round-robin arbitration.

## Interface
- `NCH`, 3, number of request channels (≥2); index 0 = hour, 1 = date, 2 = chrono.
- `PERIOD`, 396, frame length in clocks.
- `READ_LEN`, 3, `read_en` window length; 1 ≤ `READ_LEN` < `SLOT`.
- `SLOT`, 288, counter value at which arbitration happens.
- `WR_LEN`, 4, write-window length; `SLOT`+1+`WR_LEN` < `PERIOD`−1.
- `MODE`, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- `clock` in 1: single clock; all flops on rising edge.
- `reset` in 1: asynchronous assert, active-low.
- `req` in `NCH`: per-channel request level (e.g. Phora/Pfecha/Pcrono).
- `frame_start` out 1: one-cycle pulse at counter 0.
- `read_en` out 1: data-refresh enable.
- `cap_en` out `NCH`: one-hot capture strobe for the granted channel.
- `wr_en` out `NCH`: one-hot write enable for the granted channel.
- `grant_id` out max(1,$clog2(`NCH`)): index of the current grant; valid while `busy`.
- `busy` out 1: high during capture and write windows.

## Operation
- Frame counter `cnt` runs 0..`PERIOD`−1 and wraps. It never stalls or truncates; frame length is always `PERIOD`, with or without a grant.
- Pending: `pend[i]` sets on any cycle with `req[i]`=1 and clears on the cycle `cap_en[i]` is high. If set and clear coincide, clear wins; a held `req` re-sets the bit on the next cycle.
- Arbitration at `cnt`==`SLOT` over `pend | req`:
  - MODE 0: lowest set index wins.
  - MODE 1: first set index searching upward from `last`+1 mod `NCH`. `last` updates to the winner.
  - If nothing is set: no grant and no capture/write activity this frame.
- States:
  - IDLE: default.
  - CAP: `cnt`==`SLOT`+1 with a grant.
  - WR: `cnt` in `SLOT`+2..`SLOT`+1+`WR_LEN`.
  - Return to IDLE afterwards.
- Output decodes:
  - `read_en` = `cnt` < `READ_LEN`.
  - `frame_start` = `cnt`==0.
  - `cap_en[w]` in CAP.
  - `wr_en[w]` in WR.
  - `busy` = CAP|WR.
- Outputs are driven only from registered state; there is no combinational path from `req` to any output.
- At most one bit of `cap_en|wr_en` is set at any time. `cap_en` and `wr_en` are never high together.

## Timing
- Reset values:
  - `cnt`=`PERIOD`−1, state IDLE, `pend`=0, `last`=`NCH`−1, `grant_id`=0.
  - All outputs 0.
- First rising edge after `reset` deassertion: `cnt`=0, `frame_start`=1, `read_en`=1.
- Request latency: a request seen on any cycle with `cnt` ≤ `SLOT` is captured at `SLOT`+1 in the same frame. A request seen after that waits for the next frame's slot.
- Pulse widths: `read_en` lasts `READ_LEN` cycles, `cap_en` 1 cycle, `wr_en` `WR_LEN` cycles.
- `grant_id` is stable from CAP through the end of WR.
- Reset asserted mid-frame or mid-write: all outputs drop asynchronously and `pend` is lost. The aborted write is not resumed.
- Simultaneous requests: exactly one grant per frame. Losers stay pending for later frames.

## Structure
- Package `frame_sched_pkg`:
  - State enum (IDLE/CAP/WR).
  - `MODE_FIXED`=0, `MODE_RR`=1.
  - Helper function for counter width from `PERIOD`.
- Sub-module `sched_arbiter` (combinational, parametrised by `NCH`/`MODE`):
  - Inputs: request vector and `last`.
  - Outputs: `valid` and `winner`.
- The top level holds the counter, `pend`, `last`, the FSM and the output decode.

## Test plan
- Reset release, no `req`: `frame_start` pulses at cycles 0, 396, 792. `read_en` is high at cycles 0–2 of each frame. `cap_en`/`wr_en`/`busy` stay 0.
- Single pulse: `req[1]` high for one cycle at `cnt`=100 → `cap_en`=3'b010 at `cnt`=289, `wr_en`=3'b010 at 290–293, `grant_id`=1. `pend` is clear afterwards, so nothing happens in the next frame.
- MODE 0, `req`=3'b111 held for 3 frames → every grant is channel 0.
- MODE 1, same stimulus → grants 0, 1, 2 in consecutive frames.
- Late request: `req[2]` pulse at `cnt`=300 → no grant this frame, grant at 289 of the next frame.
- Reset asserted at `cnt`=291 during WR → `wr_en` drops immediately. After release, the frame restarts at `cnt`=0 with `pend`=0.
